// File: rtl/snake_pkg.sv
// Shared constants and types for the snake board renderer: cell codes, colours,
// board geometry and the divide-by-20 helper used for pixel-to-cell mapping.
package snake_pkg;

   localparam int GRID_W      = 32;
   localparam int GRID_H      = 24;
   localparam int CELL_PX     = 20;
   localparam int DIV20_MUL   = 205;
   localparam int DIV20_SHIFT = 12;

   typedef enum logic [1:0] {
      CELL_EMPTY = 2'd0,
      CELL_BODY  = 2'd1,
      CELL_HEAD  = 2'd2,
      CELL_FOOD  = 2'd3
   } cell_t;

   localparam logic [11:0] C_BLACK  = 12'h000;
   localparam logic [11:0] C_WHITE  = 12'hFFF;
   localparam logic [11:0] C_RED    = 12'hF00;
   localparam logic [11:0] C_GREEN  = 12'h0F0;
   localparam logic [11:0] C_BLUE   = 12'h00F;
   localparam logic [11:0] C_ORANGE = 12'hF80;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } clr_state_t;

   typedef struct packed {
      logic in_range;
      logic wall;
   } pix_flags_t;

   // (p*205)>>12 equals p/20 for every on-screen coordinate; off-screen results
   // wrap in 5 bits but are masked by the range flag downstream.
   function automatic logic [4:0] div20(input logic [9:0] p);
      logic [17:0] prod;
      prod = {8'd0, p} * 18'(DIV20_MUL);
      return prod[DIV20_SHIFT +: 5];
   endfunction

endpackage

// File: rtl/board_cell_ram.sv
// Board cell storage: simple dual-port RAM, one synchronous write and one
// registered read port. Not reset; read-during-write returns the old value.
module board_cell_ram #(
   parameter int AW = 10,
   parameter int DW = 2
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem_q [0:(1<<AW)-1];
   logic [DW-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we) mem_q[waddr] <= wdata;
      rdata_q <= mem_q[raddr];
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/snake_pixel_renderer.sv
// Pixel colour source for the VGA stage: maps pixel coordinates to board cells,
// looks them up in the board RAM and emits RGB444 with a fixed 3-cycle latency.
module snake_pixel_renderer #(
   parameter int CELL_PX = 20,
   parameter int GRID_W  = 32,
   parameter int GRID_H  = 24
) (
   input  logic        clk25,
   input  logic        rst_n,
   input  logic [9:0]  pix_h,
   input  logic [9:0]  pix_v,
   output logic [11:0] data,
   input  logic        wr_en,
   input  logic [4:0]  wr_x,
   input  logic [4:0]  wr_y,
   input  logic [1:0]  wr_cell,
   input  logic        clear_req,
   input  logic        game_over,
   output logic        busy
);
   import snake_pkg::*;

   localparam logic [9:0] PIX_W    = 10'(GRID_W * CELL_PX);
   localparam logic [9:0] PIX_H    = 10'(GRID_H * CELL_PX);
   localparam logic [9:0] CNT_LAST = 10'(GRID_W * GRID_H - 1);
   localparam logic [4:0] COL_LAST = 5'(GRID_W - 1);
   localparam logic [4:0] ROW_LAST = 5'(GRID_H - 1);

   clr_state_t  state_q, state_d;
   logic [9:0]  cnt_q, cnt_d;
   logic        ram_we;
   logic [9:0]  ram_waddr;
   logic [1:0]  ram_wdata;

   assign busy = (state_q == ST_CLEAR);

   // Clear sequencer owns the write port while busy; game writes only in IDLE.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      ram_we    = 1'b0;
      ram_waddr = {wr_y, wr_x};
      ram_wdata = wr_cell;
      case (state_q)
         ST_IDLE: begin
            ram_we = wr_en && ({1'b0, wr_x} < 6'(GRID_W)) && ({1'b0, wr_y} < 6'(GRID_H));
            if (clear_req) begin
               state_d = ST_CLEAR;
               cnt_d   = '0;
            end
         end
         ST_CLEAR: begin
            ram_we    = 1'b1;
            ram_waddr = cnt_q;
            ram_wdata = CELL_EMPTY;
            if (cnt_q == CNT_LAST) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 10'd1;
            end
         end
         default: state_d = ST_CLEAR;
      endcase
   end

   always_ff @(posedge clk25 or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_CLEAR;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // S1: cell index and per-pixel flags
   logic [4:0]  col_d, row_d, col_q, row_q;
   pix_flags_t  flags1_d, flags1_q, flags2_q;

   always_comb begin
      col_d             = div20(pix_h);
      row_d             = div20(pix_v);
      flags1_d.in_range = (pix_h < PIX_W) && (pix_v < PIX_H);
      flags1_d.wall     = (col_d == 5'd0) || (col_d == COL_LAST) ||
                          (row_d == 5'd0) || (row_d == ROW_LAST);
   end

   always_ff @(posedge clk25 or negedge rst_n) begin
      if (!rst_n) begin
         col_q    <= '0;
         row_q    <= '0;
         flags1_q <= '0;
         flags2_q <= '0;
      end else begin
         col_q    <= col_d;
         row_q    <= row_d;
         flags1_q <= flags1_d;
         flags2_q <= flags1_q;
      end
   end

   // S2: RAM read, flags ride alongside in flags2_q
   logic [1:0] rd_cell;

   board_cell_ram #(.AW(10), .DW(2)) u_ram (
      .clk   (clk25),
      .we    (ram_we),
      .waddr (ram_waddr),
      .wdata (ram_wdata),
      .raddr ({row_q, col_q}),
      .rdata (rd_cell)
   );

   // S3: colour
   logic [11:0] data_d, data_q;

   always_comb begin
      data_d = C_BLACK;
      if (!busy && flags2_q.in_range) begin
         if (flags2_q.wall) begin
            data_d = C_WHITE;
         end else begin
            case (cell_t'(rd_cell))
               CELL_EMPTY: data_d = C_BLACK;
               CELL_BODY:  data_d = game_over ? C_RED    : C_GREEN;
               CELL_HEAD:  data_d = game_over ? C_ORANGE : C_BLUE;
               CELL_FOOD:  data_d = C_RED;
               default:    data_d = C_BLACK;
            endcase
         end
      end
   end

   always_ff @(posedge clk25 or negedge rst_n) begin
      if (!rst_n) data_q <= C_BLACK;
      else        data_q <= data_d;
   end

   assign data = data_q;

endmodule
